// File: rtl/data_bus_responder.sv
// Target end of the core's data bus: word-organised RAM with byte lanes,
// programmable wait states and alignment/range fault detection.
module data_bus_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
  parameter int          DEPTH_WORDS = 256,
  parameter int          WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wd,
  input  logic        rd,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        ready,
  output logic        busy,
  output logic        ack,
  output logic        fault
);

  localparam int          AW        = $clog2(DEPTH_WORDS);
  localparam logic [32:0] END_ADDR  = {1'b0, BASE_ADDR} + 33'(4 * DEPTH_WORDS);
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACCESS, ST_RESP} state_t;

  state_t      state_reg, state_next;
  logic        started_reg;
  logic [3:0]  wait_cnt_reg;
  logic        wd_reg, rd_reg;
  logic [1:0]  size_reg;
  logic [31:0] addr_reg, data_reg;
  logic        fault_reg;
  logic [31:0] data_out_reg;

  logic          accept;
  logic          misalign, out_of_range, access_fault;
  logic [AW-1:0] word_idx;
  logic [1:0]    lane;
  logic [3:0]    be;
  logic [31:0]   wdata, rd_word, shifted, load_data;
  logic          write_en;

  assign accept = (state_reg == ST_IDLE) && started_reg && (wd || rd);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= ST_IDLE;
    else      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:   if (accept) state_next = (WAIT_INIT != 4'd0) ? ST_WAIT : ST_ACCESS;
      ST_WAIT:   if (wait_cnt_reg <= 4'd1) state_next = ST_ACCESS;
      ST_ACCESS: state_next = ST_RESP;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    ready    = (state_reg == ST_IDLE) && started_reg;
    busy     = (state_reg == ST_WAIT) || (state_reg == ST_ACCESS);
    ack      = (state_reg == ST_RESP);
    fault    = ack && fault_reg;
    data_out = data_out_reg;
  end

  // Decode of the latched request; only consumed while in ACCESS.
  always_comb begin
    lane         = addr_reg[1:0];
    word_idx     = AW'((addr_reg - BASE_ADDR) >> 2);
    misalign     = ((size_reg == 2'b01) && addr_reg[0]) ||
                   ((size_reg == 2'b10) && (addr_reg[1:0] != 2'b00));
    out_of_range = (addr_reg < BASE_ADDR) || ({1'b0, addr_reg} >= END_ADDR);
    access_fault = (wd_reg && rd_reg) || (size_reg == 2'b11) || misalign || out_of_range;
    write_en     = (state_reg == ST_ACCESS) && wd_reg && !access_fault;
  end

  always_comb begin
    case (size_reg)
      2'b00: begin
        be    = 4'b0001 << lane;
        wdata = {4{data_reg[7:0]}};
      end
      2'b01: begin
        be    = addr_reg[1] ? 4'b1100 : 4'b0011;
        wdata = {2{data_reg[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wdata = data_reg;
      end
    endcase
  end

  // One RAM per byte lane so byte enables never need a read-modify-write.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] lane_mem [DEPTH_WORDS];
      always_ff @(posedge clk) begin
        if (write_en && be[gi]) lane_mem[word_idx] <= wdata[8*gi +: 8];
      end
      assign rd_word[8*gi +: 8] = lane_mem[word_idx];
    end
  endgenerate

  always_comb begin
    shifted = rd_word >> {lane, 3'b000};
    case (size_reg)
      2'b00:   load_data = {24'd0, shifted[7:0]};
      2'b01:   load_data = {16'd0, shifted[15:0]};
      default: load_data = rd_word;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      started_reg  <= 1'b0;
      wait_cnt_reg <= 4'd0;
      wd_reg       <= 1'b0;
      rd_reg       <= 1'b0;
      size_reg     <= 2'b00;
      addr_reg     <= 32'd0;
      data_reg     <= 32'd0;
      fault_reg    <= 1'b0;
      data_out_reg <= 32'd0;
    end else begin
      started_reg <= 1'b1;
      if (accept) begin
        wd_reg       <= wd;
        rd_reg       <= rd;
        size_reg     <= size;
        addr_reg     <= addr;
        data_reg     <= data_in;
        wait_cnt_reg <= WAIT_INIT;
      end else if ((state_reg == ST_WAIT) && (wait_cnt_reg != 4'd0)) begin
        wait_cnt_reg <= wait_cnt_reg - 4'd1;
      end
      if (state_reg == ST_ACCESS) begin
        fault_reg <= access_fault;
        if (rd_reg) data_out_reg <= access_fault ? 32'd0 : load_data;
      end
    end
  end

endmodule

// File: tb/tb_data_bus_responder.sv
// Bench for data_bus_responder: directed plan steps plus randomized traffic
// checked against a byte-array reference model.
module tb_data_bus_responder;

  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam int          DEPTH = 256;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        a_wd = 0, a_rd = 0;
  logic [1:0]  a_size = 0;
  logic [31:0] a_addr = 0, a_data_in = 0;
  logic [31:0] a_data_out;
  logic        a_ready, a_busy, a_ack, a_fault;

  logic        b_wd = 0, b_rd = 0;
  logic [1:0]  b_size = 0;
  logic [31:0] b_addr = 0, b_data_in = 0;
  logic [31:0] b_data_out;
  logic        b_ready, b_busy, b_ack, b_fault;

  data_bus_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(1)) u_a (
    .clk(clk), .rst(rst), .wd(a_wd), .rd(a_rd), .size(a_size), .addr(a_addr),
    .data_in(a_data_in), .data_out(a_data_out), .ready(a_ready), .busy(a_busy),
    .ack(a_ack), .fault(a_fault)
  );

  data_bus_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) u_b (
    .clk(clk), .rst(rst), .wd(b_wd), .rd(b_rd), .size(b_size), .addr(b_addr),
    .data_in(b_data_in), .data_out(b_data_out), .ready(b_ready), .busy(b_busy),
    .ack(b_ack), .fault(b_fault)
  );

  int tests = 0;
  int fails = 0;

  logic [7:0]  mbytes [0:4*DEPTH-1];
  logic [31:0] m_dout = 32'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: the access is a run of nb little-endian bytes starting at addr.
  task automatic model(input logic w, input logic r, input logic [1:0] sz,
                       input logic [31:0] ad, input logic [31:0] dat,
                       output logic ef, output logic [31:0] ed);
    int nb;
    int off;
    logic [31:0] v;
    nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    ef = (w && r) || (sz == 2'd3) || ((ad % 32'(nb)) != 0) ||
         (ad < BASE) || (ad >= BASE + 32'(4 * DEPTH));
    if (!ef) begin
      off = int'(ad - BASE);
      if (w) begin
        for (int i = 0; i < nb; i++) mbytes[off + i] = dat[8*i +: 8];
      end else begin
        v = 32'd0;
        for (int i = 0; i < nb; i++) v = v | (32'(mbytes[off + i]) << (8 * i));
        m_dout = v;
      end
    end else if (r) begin
      m_dout = 32'd0;
    end
    ed = m_dout;
  endtask

  task automatic txn_a(input string tag, input logic w, input logic r, input logic [1:0] sz,
                       input logic [31:0] ad, input logic [31:0] dat);
    int n;
    logic ef;
    logic [31:0] ed;
    n = 0;
    @(negedge clk);
    while (!a_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_ready"}, 32'(a_ready), 32'd1);
    a_wd = w; a_rd = r; a_size = sz; a_addr = ad; a_data_in = dat;
    @(posedge clk);
    #1 a_wd = 0; a_rd = 0;
    n = 1;
    @(negedge clk);
    while (!a_ack && n < 20) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    model(w, r, sz, ad, dat, ef, ed);
    chk({tag, "_latency"}, 32'(n), 32'd3);
    chk({tag, "_fault"}, 32'(a_fault), 32'(ef));
    chk({tag, "_data_out"}, a_data_out, ed);
    $display("[TB] %s wd=%0b rd=%0b size=%0d addr=%h din=%h -> lat=%0d fault=%0b dout=%h",
             tag, w, r, sz, ad, dat, n, a_fault, a_data_out);
    @(negedge clk);
    chk({tag, "_ack_width"}, 32'(a_ack), 32'd0);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      tests++;
      assert (!(a_ready && a_busy) && !(b_ready && b_busy)) else begin
        fails++;
        $error("FAIL ready_busy: observed a=%b%b b=%b%b required not both high",
               a_ready, a_busy, b_ready, b_busy);
      end
    end
  end

  initial begin
    logic [31:0] r32;
    logic [1:0]  rsz;
    int          sel;

    // Reset state
    #12;
    chk("rst_ready", 32'(a_ready), 32'd0);
    chk("rst_busy", 32'(a_busy), 32'd0);
    chk("rst_ack", 32'(a_ack), 32'd0);
    chk("rst_fault", 32'(a_fault), 32'd0);
    chk("rst_data_out", a_data_out, 32'd0);
    @(negedge clk);
    rst = 1;
    #1 chk("rel_ready_before_edge", 32'(a_ready), 32'd0);
    @(posedge clk);
    #1 chk("rel_ready_first_edge", 32'(a_ready), 32'd1);

    // Fill the whole RAM so the model knows every byte
    for (int i = 0; i < DEPTH; i++)
      txn_a("init", 1'b1, 1'b0, 2'd2, BASE + 32'(4 * i), $urandom);

    txn_a("w_pre", 1'b1, 1'b0, 2'd2, 32'h1000, 32'h11223344);

    // Reset mid-WAIT aborts the DEADBEEF store
    @(negedge clk);
    a_wd = 1; a_size = 2'd2; a_addr = 32'h1000; a_data_in = 32'hDEADBEEF;
    @(posedge clk);
    #1 a_wd = 0;
    @(negedge clk);
    chk("abort_busy_in_wait", 32'(a_busy), 32'd1);
    rst = 0;
    m_dout = 32'd0;
    #1;
    chk("abort_busy", 32'(a_busy), 32'd0);
    chk("abort_ready", 32'(a_ready), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1;
    #1 chk("abort_ready_released", 32'(a_ready), 32'd0);
    @(posedge clk);
    #1 chk("abort_ready_edge", 32'(a_ready), 32'd1);
    txn_a("r_after_abort", 1'b0, 1'b1, 2'd2, 32'h1000, 32'd0);
    chk("r_after_abort_const", a_data_out, 32'h11223344);

    // Lane selection on loads and stores
    txn_a("rb_1002", 1'b0, 1'b1, 2'd0, 32'h1002, 32'd0);
    chk("rb_1002_const", a_data_out, 32'h00000022);
    txn_a("rh_1002", 1'b0, 1'b1, 2'd1, 32'h1002, 32'd0);
    chk("rh_1002_const", a_data_out, 32'h00001122);
    txn_a("wb_1001", 1'b1, 1'b0, 2'd0, 32'h1001, 32'hFFFF_FFAB);
    txn_a("rw_1000", 1'b0, 1'b1, 2'd2, 32'h1000, 32'd0);
    chk("rw_1000_const", a_data_out, 32'h1122AB44);

    // Misaligned / illegal size
    txn_a("rw_mis", 1'b0, 1'b1, 2'd2, 32'h1002, 32'd0);
    txn_a("wh_mis", 1'b1, 1'b0, 2'd1, 32'h1001, 32'h0000_5555);
    txn_a("r_sz3", 1'b0, 1'b1, 2'd3, 32'h1000, 32'd0);
    txn_a("rw_unch", 1'b0, 1'b1, 2'd2, 32'h1000, 32'd0);
    chk("rw_unch_const", a_data_out, 32'h1122AB44);

    // Range boundaries and conflicting direction
    txn_a("r_last", 1'b0, 1'b1, 2'd2, 32'h13FC, 32'd0);
    txn_a("r_end", 1'b0, 1'b1, 2'd2, 32'h1400, 32'd0);
    txn_a("r_below", 1'b0, 1'b1, 2'd2, 32'h0FFC, 32'd0);
    txn_a("wd_rd", 1'b1, 1'b1, 2'd2, 32'h1000, 32'h0BAD_0BAD);

    // Randomized traffic around the mapped window
    for (int i = 0; i < 300; i++) begin
      r32 = 32'h0FF8 + 32'($urandom_range(0, 4 * DEPTH + 16));
      rsz = 2'($urandom_range(0, 3));
      sel = int'($urandom_range(0, 9));
      txn_a("rand", (sel <= 5), (sel == 0) || (sel > 5), rsz, r32, $urandom);
    end

    // Back-to-back with no wait states, request held continuously
    @(negedge clk);
    b_wd = 1; b_size = 2'd2; b_addr = 32'h1004; b_data_in = 32'hCAFEF00D;
    for (int n = 1; n <= 15; n++) begin
      @(posedge clk);
      @(negedge clk);
      chk("b2b_ack", 32'(b_ack), 32'((n % 3) == 2));
      chk("b2b_ready", 32'(b_ready), 32'((n % 3) == 0));
      $display("[TB] b2b cycle=%0d ack=%0b ready=%0b busy=%0b", n, b_ack, b_ready, b_busy);
    end
    b_wd = 0; b_rd = 1;
    @(posedge clk);
    #1 b_rd = 0;
    @(negedge clk);
    @(negedge clk);
    chk("b_read_ack", 32'(b_ack), 32'd1);
    chk("b_read_fault", 32'(b_fault), 32'd0);
    chk("b_read_data", b_data_out, 32'hCAFEF00D);
    $display("[TB] b read addr=00001004 dout=%h fault=%0b", b_data_out, b_fault);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
